// File: rtl/pre_if_stage.sv
// Pre-IF fetch-request stage: owns the fetch PC, issues one instruction-bus read at a time,
// buffers the returned word for IF and applies branch / exception / eret redirects.
module pre_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'hbfc0_0000,
  parameter logic [31:0] EX_ENTRY  = 32'hbfc0_0380,
  parameter int          BR_BUS_WD = 33
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fs_allowin,
  input  logic [BR_BUS_WD-1:0] br_bus,
  input  logic                 ex_from_ws,
  input  logic                 eret_from_ws,
  input  logic [31:0]          cp0_epc,
  output logic                 inst_sram_req,
  output logic                 inst_sram_wr,
  output logic [1:0]           inst_sram_size,
  output logic [31:0]          inst_sram_addr,
  output logic [31:0]          inst_sram_wdata,
  input  logic                 inst_sram_addr_ok,
  input  logic                 inst_sram_data_ok,
  input  logic [31:0]          inst_sram_rdata,
  output logic                 ps_to_fs_valid,
  output logic [64:0]          ps_to_fs_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  logic [1:0]  state,    state_nxt;
  logic [31:0] ps_pc,    ps_pc_nxt;
  logic [31:0] req_pc,   req_pc_nxt;
  logic [31:0] br_tgt_q, br_tgt_nxt;
  logic        pend_br,  pend_br_nxt;
  logic        discard,  discard_nxt;
  logic [64:0] fs_buf,   fs_buf_nxt;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] flush_tgt;
  logic        req_hold;

  assign br_taken  = br_bus[BR_BUS_WD-1];
  assign br_target = br_bus[31:0];
  assign flush_tgt = eret_from_ws ? cp0_epc : EX_ENTRY;

  // A misaligned fetch address never reaches the bus; it becomes an ADEF entry instead.
  assign inst_sram_req   = (state == S_REQ) && (req_pc[1:0] == 2'b00);
  assign inst_sram_addr  = req_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wdata = 32'h0;

  assign req_hold = inst_sram_req && !inst_sram_addr_ok;

  assign ps_to_fs_valid = (state == S_FULL) && !ex_from_ws;
  assign ps_to_fs_bus   = fs_buf;

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_nxt   = state;
    ps_pc_nxt   = ps_pc;
    br_tgt_nxt  = br_tgt_q;
    pend_br_nxt = pend_br;
    discard_nxt = discard;
    fs_buf_nxt  = fs_buf;

    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (br_taken) ps_pc_nxt = br_target;
      end
      S_REQ: begin
        if (!inst_sram_req) begin
          state_nxt  = S_FULL;
          fs_buf_nxt = {1'b1, 32'h0, req_pc};
        end else if (inst_sram_addr_ok) begin
          state_nxt = S_WAIT;
        end
        if (inst_sram_req && br_taken && !discard) begin
          pend_br_nxt = 1'b1;
          br_tgt_nxt  = br_target;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (discard) begin
            state_nxt   = S_REQ;
            discard_nxt = 1'b0;
          end else begin
            state_nxt   = S_FULL;
            fs_buf_nxt  = {1'b0, inst_sram_rdata, ps_pc};
            pend_br_nxt = 1'b0;
            // The fetched word is the delay slot; a branch arriving now redirects past it.
            if (br_taken)     ps_pc_nxt = br_target;
            else if (pend_br) ps_pc_nxt = br_tgt_q;
            else              ps_pc_nxt = ps_pc + 32'd4;
          end
        end else if (br_taken && !discard) begin
          pend_br_nxt = 1'b1;
          br_tgt_nxt  = br_target;
        end
      end
      default: begin  // S_FULL: an ADEF entry is only cleared by a flush
        if (fs_allowin && !fs_buf[64]) state_nxt = S_REQ;
        if (br_taken) ps_pc_nxt = br_target;
      end
    endcase

    // Flush overrides everything above; an accepted request still has to drain its data.
    if (ex_from_ws) begin
      ps_pc_nxt   = flush_tgt;
      pend_br_nxt = 1'b0;
      br_tgt_nxt  = br_tgt_q;
      fs_buf_nxt  = fs_buf;
      case (state)
        S_REQ: begin
          discard_nxt = inst_sram_req;
          state_nxt   = (inst_sram_req && inst_sram_addr_ok) ? S_WAIT : S_REQ;
        end
        S_WAIT: begin
          discard_nxt = !inst_sram_data_ok;
          state_nxt   = inst_sram_data_ok ? S_REQ : S_WAIT;
        end
        default: begin
          discard_nxt = 1'b0;
          state_nxt   = S_REQ;
        end
      endcase
    end

    // The bus address is frozen while a request waits for addr_ok, otherwise it tracks ps_pc.
    req_pc_nxt = req_hold ? req_pc : ps_pc_nxt;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state    <= S_IDLE;
      ps_pc    <= RESET_PC;
      req_pc   <= RESET_PC;
      br_tgt_q <= 32'h0;
      pend_br  <= 1'b0;
      discard  <= 1'b0;
      fs_buf   <= 65'h0;
    end else begin
      state    <= state_nxt;
      ps_pc    <= ps_pc_nxt;
      req_pc   <= req_pc_nxt;
      br_tgt_q <= br_tgt_nxt;
      pend_br  <= pend_br_nxt;
      discard  <= discard_nxt;
      fs_buf   <= fs_buf_nxt;
    end
  end

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed + randomized bench for pre_if_stage: a transaction-level program-flow model
// predicts every bus address and every instruction handed to IF.
module tb_pre_if_stage;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
  localparam logic [31:0] EX_ENTRY = 32'hbfc0_0380;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_allowin;
  logic [32:0] br_bus;
  logic        ex_from_ws;
  logic        eret_from_ws;
  logic [31:0] cp0_epc;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ps_to_fs_valid;
  logic [64:0] ps_to_fs_bus;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  pre_if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .fs_allowin        (fs_allowin),
    .br_bus            (br_bus),
    .ex_from_ws        (ex_from_ws),
    .eret_from_ws      (eret_from_ws),
    .cp0_epc           (cp0_epc),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .ps_to_fs_valid    (ps_to_fs_valid),
    .ps_to_fs_bus      (ps_to_fs_bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic raise_flush(input bit with_br, input bit eret, input logic [31:0] epc);
    ex_from_ws   = 1'b1;
    eret_from_ws = eret;
    cp0_epc      = epc;
    if (with_br) br_bus = {1'b1, 32'h8000_0100};
  endtask

  task automatic drop_flush();
    ex_from_ws   = 1'b0;
    eret_from_ws = 1'b0;
    br_bus       = 33'h0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!inst_sram_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 67'(inst_sram_req), 67'(1'b1));
  endtask

  // One complete fetch of exp_pc. br_when: 0 none, 1 with addr_ok, 2 first WAIT cycle,
  // 3 first FULL cycle. The program-flow model then advances exp_pc.
  task automatic fetch(input int addr_dly, input int data_dly, input int stall,
                       input int br_when, input logic [31:0] tgt);
    logic [31:0] data;
    logic [64:0] exp_bus;
    data = 32'h0;
    wait_req();
    check("req_addr", 67'(inst_sram_addr), 67'(exp_pc));
    for (int i = 0; i < addr_dly; i++) begin
      tick();
      check("req_hold", 67'({inst_sram_req, inst_sram_addr}), 67'({1'b1, exp_pc}));
    end
    inst_sram_addr_ok = 1'b1;
    if (br_when == 1) br_bus = {1'b1, tgt};
    tick();
    inst_sram_addr_ok = 1'b0;
    br_bus = 33'h0;
    for (int i = 0; i <= data_dly; i++) begin
      check("wait_quiet", 67'({inst_sram_req, ps_to_fs_valid}), 67'(2'b00));
      if (i == 0 && br_when == 2) br_bus = {1'b1, tgt};
      if (i == data_dly) begin
        data = $urandom;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = data;
      end
      tick();
      br_bus = 33'h0;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = $urandom;
    end
    exp_bus = {1'b0, data, exp_pc};
    for (int i = 0; i < stall; i++) begin
      check("full_hold", 67'({ps_to_fs_valid, inst_sram_req, ps_to_fs_bus}), {2'b10, exp_bus});
      if (i == 0 && br_when == 3) br_bus = {1'b1, tgt};
      tick();
      br_bus = 33'h0;
    end
    check("deliver", 67'({ps_to_fs_valid, inst_sram_req, ps_to_fs_bus}), {2'b10, exp_bus});
    fs_allowin = 1'b1;
    if (stall == 0 && br_when == 3) br_bus = {1'b1, tgt};
    tick();
    fs_allowin = 1'b0;
    br_bus = 33'h0;
    exp_pc = (br_when != 0) ? tgt : exp_pc + 32'd4;
    check("rereq_after_pop", 67'(inst_sram_req), 67'(1'b1));
  endtask

  // where: 0 flush in WAIT with data 3 cycles later, 1 flush with data_ok, 2 flush in REQ.
  task automatic flush_test(input int where, input bit with_br, input bit eret,
                            input logic [31:0] epc);
    logic [31:0] tgt;
    tgt = eret ? epc : EX_ENTRY;
    wait_req();
    check("flush_pre_addr", 67'(inst_sram_addr), 67'(exp_pc));
    if (where == 2) begin
      raise_flush(with_br, eret, epc);
      tick();
      drop_flush();
      check("flush_req_hold", 67'({inst_sram_req, inst_sram_addr}), 67'({1'b1, exp_pc}));
      inst_sram_addr_ok = 1'b1;
      tick();
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = $urandom;
      tick();
      inst_sram_data_ok = 1'b0;
    end else begin
      inst_sram_addr_ok = 1'b1;
      tick();
      inst_sram_addr_ok = 1'b0;
      raise_flush(with_br, eret, epc);
      if (where == 1) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = $urandom;
      end
      tick();
      drop_flush();
      inst_sram_data_ok = 1'b0;
      if (where == 0) begin
        tick();
        tick();
        check("flush_wait_quiet", 67'({ps_to_fs_valid, inst_sram_req}), 67'(2'b00));
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = $urandom;
        tick();
        inst_sram_data_ok = 1'b0;
      end
    end
    check("flush_redirect", 67'({ps_to_fs_valid, inst_sram_req, inst_sram_addr}),
          67'({1'b0, 1'b1, tgt}));
    exp_pc = tgt;
  endtask

  task automatic adef_test();
    logic seen;
    int   n;
    wait_req();
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    raise_flush(1'b0, 1'b1, 32'h8000_0203);
    tick();
    drop_flush();
    tick();
    inst_sram_data_ok = 1'b1;
    tick();
    inst_sram_data_ok = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!ps_to_fs_valid && n < 10) begin
      seen = seen | inst_sram_req;
      tick();
      n++;
    end
    seen = seen | inst_sram_req;
    check("adef_no_req", 67'(seen), 67'(1'b0));
    check("adef_bus", 67'({ps_to_fs_valid, ps_to_fs_bus}), 67'({1'b1, 1'b1, 32'h0, 32'h8000_0203}));
    fs_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("adef_hold", 67'({ps_to_fs_valid, inst_sram_req, ps_to_fs_bus}),
            {2'b10, 1'b1, 32'h0, 32'h8000_0203});
    end
    raise_flush(1'b0, 1'b1, 32'h8000_0200);
    #1;
    check("flush_masks_pop", 67'(ps_to_fs_valid), 67'(1'b0));
    tick();
    drop_flush();
    fs_allowin = 1'b0;
    check("eret_redirect", 67'({ps_to_fs_valid, inst_sram_req, inst_sram_addr}),
          67'({1'b0, 1'b1, 32'h8000_0200}));
    exp_pc = 32'h8000_0200;
  endtask

  initial begin
    reset             = 1'b1;
    fs_allowin        = 1'b0;
    br_bus            = 33'h0;
    ex_from_ws        = 1'b0;
    eret_from_ws      = 1'b0;
    cp0_epc           = 32'h0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    exp_pc            = RESET_PC;
    repeat (3) tick();
    check("reset_outputs", 67'({ps_to_fs_valid, inst_sram_req, ps_to_fs_bus}), 67'(0));
    check("bus_constants", 67'({inst_sram_wr, inst_sram_size, inst_sram_wdata}),
          67'({1'b0, 2'b10, 32'h0}));
    reset = 1'b0;

    // Back-to-back fetches with zero-latency bus
    for (int i = 0; i < 4; i++) fetch(0, 0, 0, 0, 32'h0);
    // IF stalls for five cycles
    fetch(0, 0, 5, 0, 32'h0);
    // Branch while waiting for data: delay slot delivered, then target fetched
    fetch(1, 2, 0, 2, 32'h8000_0100);
    fetch(0, 0, 0, 0, 32'h0);
    // Exception flushes an in-flight fetch
    flush_test(0, 1'b0, 1'b0, 32'h0);
    fetch(0, 0, 0, 0, 32'h0);
    // Flush together with a branch, with data_ok, and while the request is held
    flush_test(0, 1'b1, 1'b0, 32'h0);
    fetch(0, 0, 0, 0, 32'h0);
    flush_test(1, 1'b0, 1'b0, 32'h0);
    fetch(0, 1, 0, 0, 32'h0);
    flush_test(2, 1'b0, 1'b1, 32'h8000_1000);
    fetch(0, 0, 0, 0, 32'h0);
    // eret to a misaligned EPC
    adef_test();
    fetch(0, 0, 0, 0, 32'h0);

    // Random bus latencies, IF stalls and branches
    for (int k = 0; k < 40; k++) begin
      logic [31:0] t;
      int          bw;
      t  = $urandom;
      t[1:0] = 2'b00;
      bw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), bw, t);
    end

    // Reset during WAIT, then a late data_ok that must be ignored
    wait_req();
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_reset_outputs", 67'({ps_to_fs_valid, inst_sram_req, ps_to_fs_bus}), 67'(0));
    reset = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = $urandom;
    tick();
    inst_sram_data_ok = 1'b0;
    check("late_data_ignored", 67'({ps_to_fs_valid, inst_sram_req, inst_sram_addr}),
          67'({1'b0, 1'b1, RESET_PC}));
    exp_pc = RESET_PC;
    fetch(0, 0, 0, 0, 32'h0);
    fetch(0, 0, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
